// File: rtl/qec_link_pkg.sv
// Shared constants for the inter-FPGA link: GT word layout, tag/id fields and stats width.
package qec_link_pkg;
    localparam int GT_WIDTH    = 64;
    localparam int TAG_MSB_DEF = 55;
    localparam int TAG_LSB_DEF = 48;
    localparam int FPGA_ID_MSB = 63;
    localparam int FPGA_ID_LSB = 56;
    localparam logic [7:0] CTRL_TAG = 8'hFF;
    localparam int STATS_W     = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves past a winner on advance.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);
    logic [IW-1:0] ptr;

    always_comb begin
        logic [IW:0]   s;
        logic [IW-1:0] j;
        s         = '0;
        j         = '0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            // Search order ptr, ptr+1, ... wrapping modulo N
            s = {1'b0, ptr} + (IW+1)'(k);
            if (s >= (IW+1)'(N))
                s = s - (IW+1)'(N);
            j = s[IW-1:0];
            if (!grant_vld && req[j]) begin
                grant_vld = 1'b1;
                grant_idx = j;
            end
        end
        if (grant_vld)
            grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/border_rr_combiner.sv
// Merges border FIFO channels into one tagged GT-width stream with a 2-entry skid output.
// Optional per-channel word counters are enabled with `define COMBINER_STATS_EN.
module border_rr_combiner
    import qec_link_pkg::*;
#(
    parameter int NUM_CHANNELS      = 5,
    parameter int CHANNEL_WIDTH_IN  = 32,
    parameter int CHANNEL_WIDTH_OUT = GT_WIDTH,
    parameter int TAG_MSB           = TAG_MSB_DEF,
    parameter int TAG_LSB           = TAG_LSB_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH_IN-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]              in_valid,
    output logic [NUM_CHANNELS-1:0]              in_ready,
    output logic [CHANNEL_WIDTH_OUT-1:0]         out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    input  logic                                 stats_clear,
    output logic [NUM_CHANNELS*STATS_W-1:0]      word_count
);
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TW = TAG_MSB - TAG_LSB + 1;

    logic [NUM_CHANNELS-1:0]      grant;
    logic [IW-1:0]                grant_idx;
    logic                         grant_vld;
    logic                         transfer;
    logic                         skid_valid;
    logic [CHANNEL_WIDTH_OUT-1:0] skid_data;
    logic [CHANNEL_WIDTH_OUT-1:0] word;
    logic [CHANNEL_WIDTH_IN-1:0]  payload;

    // in_ready depends only on registered state, never on out_ready
    assign transfer = grant_vld & ~skid_valid & ~reset;
    assign in_ready = grant & {NUM_CHANNELS{~skid_valid & ~reset}};
    assign busy     = (|in_valid) | out_valid | skid_valid;

    rr_arbiter #(.N(NUM_CHANNELS), .IW(IW)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        payload = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (grant[i])
                payload = in_data[i*CHANNEL_WIDTH_IN +: CHANNEL_WIDTH_IN];
        word = '0;
        word[CHANNEL_WIDTH_IN-1:0] = payload;
        word[TAG_MSB:TAG_LSB]      = TW'(grant_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            // Skid full implies out full; drain skid into out when out fires
            if (out_ready) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (transfer) begin
            if (out_valid && !out_ready) begin
                skid_data  <= word;
                skid_valid <= 1'b1;
            end else begin
                out_data  <= word;
                out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COMBINER_STATS_EN
    logic [NUM_CHANNELS-1:0][STATS_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                if (transfer && grant[i] && cnt[i] != {STATS_W{1'b1}})
                    cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign word_count = cnt;
`else
    logic stats_unused;
    assign stats_unused = stats_clear;
    assign word_count   = '0;
`endif
endmodule

// File: tb/tb_border_rr_combiner.sv
// Self-checking bench for border_rr_combiner: directed scenarios plus random traffic vs a queue model.
module tb_border_rr_combiner;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*32-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [63:0]    out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           stats_clear;
    logic [N*16-1:0] word_count;

    border_rr_combiner dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .stats_clear (stats_clear),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: words held by the DUT in order, pointer, counters
    logic [63:0] q[$];
    int          m_ptr;
    int          m_cnt[N];
    logic [N-1:0] last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input int ch, input logic [31:0] p);
        return (64'(ch) << 48) | 64'(p);
    endfunction

    task automatic step(input logic [N-1:0] v, input logic ordy, input logic clr,
                        input logic rst, input logic [N*32-1:0] d);
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        in_valid = v; out_ready = ordy; stats_clear = clr; reset = rst; in_data = d;
        #1;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = (g >= 0 && q.size() < 2 && !rst) ? N'(1 << g) : '0;
        last_ready = in_ready;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) chk("out_data", out_data, q[0]);
        chk("busy", 64'(busy), 64'((|v) || q.size() > 0));
        for (int i = 0; i < N; i++) begin
`ifdef COMBINER_STATS_EN
            chk("word_count", 64'(word_count[i*16 +: 16]), 64'(m_cnt[i]));
`else
            chk("word_count", 64'(word_count[i*16 +: 16]), 64'd0);
`endif
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (er != '0) begin
                q.push_back(mk_word(g, d[g*32 +: 32]));
                m_ptr = (g + 1) % N;
                if (!clr && m_cnt[g] < 16'hFFFF) m_cnt[g]++;
            end
            if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
    endtask

    function automatic logic [N*32-1:0] rnd_data();
        logic [N*32-1:0] d;
        for (int i = 0; i < N; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [N*32-1:0] d;
        in_valid = '0; out_ready = 1'b1; stats_clear = 1'b0; reset = 1'b1; in_data = '0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(posedge clk);
        step('0, 1'b1, 1'b0, 1'b1, '0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", out_data, 64'd0);

        // Single word on channel 2
        d = rnd_data();
        d[2*32 +: 32] = 32'hDEADBEEF;
        step(5'b00100, 1'b1, 1'b0, 1'b0, d);
        #1;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data", out_data, 64'h0002_0000_DEAD_BEEF);
        step(5'b11111, 1'b1, 1'b0, 1'b0, rnd_data());
        chk("ptr_after_single", 64'(last_ready), 64'(5'b01000));

        // Continuous all-valid rotation
        for (int c = 0; c < 8; c++) step(5'b11111, 1'b1, 1'b0, 1'b0, rnd_data());
        step('0, 1'b1, 1'b0, 1'b0, '0);
        step('0, 1'b1, 1'b0, 1'b0, '0);

        // Backpressure from a fresh pointer
        step('0, 1'b1, 1'b0, 1'b1, '0);
        for (int c = 0; c < 3; c++) step(5'b00011, 1'b0, 1'b0, 1'b0, rnd_data());
        chk("bp_in_ready_blocked", 64'(last_ready), 64'd0);
        step('0, 1'b1, 1'b0, 1'b0, '0);
        step('0, 1'b1, 1'b0, 1'b0, '0);
        step('0, 1'b1, 1'b0, 1'b0, '0);

        // Wrap fairness: pointer to 4, then channels 1 and 4 compete
        step(5'b01000, 1'b1, 1'b0, 1'b0, rnd_data());
        step(5'b10010, 1'b1, 1'b0, 1'b0, rnd_data());
        chk("wrap_first", 64'(last_ready), 64'(5'b10000));
        step(5'b10010, 1'b1, 1'b0, 1'b0, rnd_data());
        chk("wrap_second", 64'(last_ready), 64'(5'b00010));

        // Reset with out and skid both full
        step(5'b11111, 1'b0, 1'b0, 1'b0, rnd_data());
        step(5'b11111, 1'b0, 1'b0, 1'b0, rnd_data());
        step(5'b11111, 1'b0, 1'b0, 1'b1, rnd_data());
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        step(5'b11111, 1'b1, 1'b0, 1'b0, rnd_data());
        chk("midreset_grant0", 64'(last_ready), 64'(5'b00001));

        // Random traffic
        for (int c = 0; c < 400; c++)
            step(N'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 150) == 0), rnd_data());

`ifdef COMBINER_STATS_EN
        step('0, 1'b1, 1'b0, 1'b1, '0);
        for (int c = 0; c < 70000; c++) step(5'b01000, 1'b1, 1'b0, 1'b0, rnd_data());
        #1;
        chk("stats_saturate", 64'(word_count[3*16 +: 16]), 64'hFFFF);
        step(5'b01000, 1'b1, 1'b1, 1'b0, rnd_data());
        #1;
        chk("stats_clear_priority", 64'(word_count[3*16 +: 16]), 64'd0);
`endif
        step('0, 1'b1, 1'b0, 1'b0, '0);
        step('0, 1'b1, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/border_rr_combiner.md
Name: border_rr_combiner

Overview:
- Upstream stage of the inter-FPGA message handler.
- Merges FPGA_FIFO_COUNT narrow border FIFO channels from one border (north or south) into a single tagged GT-width stream. The handler then stamps the destination FPGA id on that stream.
- Fair round-robin arbitration, channel-index tagging, and a 2-entry registered skid output, so that out_ready never reaches in_ready combinationally.

Parameters:
- NUM_CHANNELS, 5, number of narrow input channels.
- CHANNEL_WIDTH_IN, 32, payload width per channel.
- CHANNEL_WIDTH_OUT, 64, output word width.
- TAG_MSB, 55, MSB of the channel-tag field in the output word.
- TAG_LSB, 48, LSB of the channel-tag field. Constraint: TAG_LSB >= CHANNEL_WIDTH_IN, TAG_MSB < CHANNEL_WIDTH_OUT, and 2^(TAG_MSB-TAG_LSB+1) >= NUM_CHANNELS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- in_data  input  NUM_CHANNELS*CHANNEL_WIDTH_IN  packed channel payloads; channel i occupies bits [(i+1)*CHANNEL_WIDTH_IN-1 : i*CHANNEL_WIDTH_IN].
- in_valid  input  NUM_CHANNELS  per-channel valid.
- in_ready  output  NUM_CHANNELS  per-channel ready; at most one bit high per cycle.
- out_data  output  CHANNEL_WIDTH_OUT  tagged word.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.
- busy  output  1  |in_valid | out_valid | skid_valid.
- stats_clear  input  1  clears the statistics counters (see Optional Feature).
- word_count  output  NUM_CHANNELS*16  per-channel accepted-word counters.

Behaviour:
- Clock and reset: clock clk; reset synchronous, active-high (reset).
- Reset values: out_valid=0, out_data=0, skid_valid=0, rr_ptr=0, word_count=0. in_ready is 0 during the reset cycle.
- Output word format:
  - bits [CHANNEL_WIDTH_IN-1:0] = channel payload;
  - [TAG_MSB:TAG_LSB] = granted channel index, zero-extended;
  - all other bits 0.
- Arbitration (combinational grant):
  - Grant the lowest index j >= rr_ptr with in_valid[j]=1, wrapping modulo NUM_CHANNELS.
  - No valid inputs: no grant.
  - in_ready[j] = grant[j] & !skid_valid.
  - Transfer on channel j when in_valid[j] & in_ready[j].
- Pointer update: on a transfer from channel j, rr_ptr <= (j == NUM_CHANNELS-1) ? 0 : j+1. With no transfer, rr_ptr holds.
- Output stage:
  - A transfer is accepted when the skid register is empty.
  - If out_valid & !out_ready at acceptance, the word goes to the skid register. Otherwise it loads the out register, so out_valid rises the next cycle.
  - Latency: 1 cycle from input handshake to out_valid.
  - When the output fires (out_valid & out_ready) and skid_valid=1, the skid word moves to out next cycle and skid_valid clears. No input is accepted that cycle, because skid was full.
  - When the output fires with the skid empty and no new transfer, out_valid clears.
  - Words leave in acceptance order; none are lost or duplicated.
- Throughput: 1 word/cycle sustained while out_ready=1.
- out_data and out_valid are stable while out_valid & !out_ready.
- Simultaneous valid on all channels: strict rotation 0,1,2,3,4,0,...
- A channel dropping valid before its grant is not penalised; the pointer only moves on a transfer.
- Reset mid-operation: all buffered words are discarded and rr_ptr returns to 0. The upstream FIFOs retain unaccepted data.

Optional Feature:
- Macro: COMBINER_STATS_EN.
- Defined:
  - word_count[i] is a 16-bit counter that increments on each transfer from channel i and saturates at 16'hFFFF.
  - stats_clear=1 zeroes all counters next cycle; it takes priority over a same-cycle increment.
- Undefined: word_count is tied to 0 and stats_clear is ignored. The port list is unchanged.

Decomposition:
- Shared package qec_link_pkg holds:
  - GT word width constant (64);
  - tag field MSB/LSB constants (55/48);
  - FPGA-id field position [63:56];
  - control tag value 8'hFF;
  - stats counter width (16).
- One sub-module: rr_arbiter, a parameterised NUM_CHANNELS round-robin with grant one-hot, grant index and pointer register. The skid/output stage stays inline.

Test Plan:
- Single word: in_valid=5'b00100 with data 32'hDEADBEEF on channel 2, out_ready=1 -> next cycle out_valid=1, out_data=64'h0002_0000_DEAD_BEEF; rr_ptr=3.
- All channels valid continuously, out_ready=1 -> output tags in sequence 0,1,2,3,4,0,1; out_valid high every cycle after the first.
- Backpressure: out_ready=0 with channels 0 and 1 valid -> out holds ch0, skid takes ch1, in_ready=0 thereafter. On out_ready=1 -> ch0 then ch1 emitted on consecutive cycles with no loss.
- Wrap fairness: rr_ptr=4, valid on channels 1 and 4 -> ch4 granted first, then ch1.
- Reset mid-stream with out and skid full -> out_valid=0, skid empty, and the next grant starts from channel 0.
- COMBINER_STATS_EN: 70000 transfers on ch3 -> word_count[3]=16'hFFFF. stats_clear pulse asserted together with a ch3 transfer -> counter reads 0.
